// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two write lanes (lane 1 wins on collision),
// NUM_RD combinational read ports, optional bypass and a sequential clear engine.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en0,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic                     wr_en1,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data1,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PENULT_PTR = ADDR_W'(DEPTH - 2);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_ptr_q;
  logic                clr_busy_q;
  logic                clr_done_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                we0;
  logic                we1;

  // clr_done is registered, so it is raised one edge early to line up with
  // the cycle in which the last entry is being cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      clr_busy_q <= 1'b1;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_PTR) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
          end else begin
            clr_done_q <= (clr_ptr_q == PENULT_PTR);
          end
        end
        IDLE: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= CLEAR;
          clr_ptr_q  <= '0;
          clr_busy_q <= 1'b1;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign we0 = wr_en0 && (state_q == IDLE) && !((ZERO_REG != 0) && (wr_addr0 == '0));
  assign we1 = wr_en1 && (state_q == IDLE) && !((ZERO_REG != 0) && (wr_addr1 == '0));

  // Storage has no reset so it can map onto RAM; lane 1 is written last to win.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else begin
      if (we0) mem_q[wr_addr0] <= wr_data0;
      if (we1) mem_q[wr_addr1] <= wr_data1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem_q[addr];
      if (clr_busy_q) begin
        data = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_en1 && (wr_addr1 == addr)) begin
        data = wr_data1;
      end else if ((BYPASS != 0) && wr_en0 && (wr_addr0 == addr)) begin
        data = wr_data0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
  end

  assign clr_busy = clr_busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing instance and a non-bypassing
// instance share every input so same-cycle forwarding can be compared.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR*DW-1:0]  rd_data_nb;
  logic              wr_en0, wr_en1;
  logic [AW-1:0]     wr_addr0, wr_addr1;
  logic [DW-1:0]     wr_data0, wr_data1;
  logic              clr_req;
  logic              clr_busy, clr_done;
  logic              clr_busy_nb, clr_done_nb;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rd_addr  = '0;
    wr_en0   = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1   = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    clr_req  = 1'b0;
  endtask

  // Walks a clear sequence that starts in the current cycle, hammering the
  // write lanes and clr_req, which the block must ignore while busy.
  task automatic count_clear(output int nbusy, output int ndone, output int dcyc,
                             output int nzero);
    logic [AW-1:0] a;
    nbusy = 0; ndone = 0; dcyc = -1; nzero = 0;
    for (int k = 1; k <= 40; k++) begin
      a        = AW'(k - 1);
      rd_addr  = {~a, a};
      wr_en0   = 1'b1;
      wr_addr0 = (k >= 2) ? AW'(k - 2) : '0;
      wr_data0 = 32'hF000_0000 | k;
      wr_en1   = 1'b1;
      wr_addr1 = (k >= 2) ? AW'(k - 2) : '0;
      wr_data1 = 32'hE000_0000 | k;
      clr_req  = 1'b1;
      #1;
      if (!clr_busy) begin
        wr_en0  = 1'b0;
        wr_en1  = 1'b0;
        clr_req = 1'b0;
        break;
      end
      nbusy++;
      if (clr_done) begin
        ndone++;
        dcyc = k;
      end
      if (rd_data !== '0) nzero++;
      @(negedge clk);
    end
    wr_en0 = 1'b0; wr_en1 = 1'b0; clr_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (clr_done) ndone++;
    end
    @(negedge clk);
  endtask

  task automatic sweep_zero(output int bad);
    logic [AW-1:0] a;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      a       = AW'(i);
      rd_addr = {AW'(DEPTH - 1 - i), a};
      #1;
      if (rd_data !== '0 || rd_data_nb !== '0) bad++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    int nbusy, ndone, dcyc, nzero, bad;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (clr_busy !== 1'b1 || clr_busy_nb !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_busy: got %b/%b expected 1", clr_busy, clr_busy_nb);
    end
    n_checks++;
    if (clr_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", clr_done);
    end
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++; $display("[TB] FAIL reset_rd: got %h expected 0", rd_data);
    end
    reset = 1'b1;
    count_clear(nbusy, ndone, dcyc, nzero);
    n_checks++;
    if (nbusy != DEPTH) begin
      n_fail++; $display("[TB] FAIL reset_busy_cycles: got %0d expected %0d", nbusy, DEPTH);
    end
    n_checks++;
    if (ndone != 1 || dcyc != DEPTH) begin
      n_fail++; $display("[TB] FAIL reset_done_pulse: got %0d pulses at cycle %0d expected 1 at %0d", ndone, dcyc, DEPTH);
    end
    n_checks++;
    if (nzero != 0) begin
      n_fail++; $display("[TB] FAIL reset_rd_busy: got %0d nonzero reads expected 0", nzero);
    end
    sweep_zero(bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL reset_sweep: got %0d nonzero entries expected 0", bad);
    end
  endtask

  task automatic test_basic();
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en0 = 1'b0;
    rd_addr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hDEAD_BEEF || rd_data_nb[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL basic_r5: got %h/%h expected deadbeef", rd_data[31:0], rd_data_nb[31:0]);
    end
    n_checks++;
    if (rd_data[63:32] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL basic_r0_port1: got %h expected 0", rd_data[63:32]);
    end
    @(negedge clk);
    wr_en0 = 1'b1; wr_addr0 = 5'd0; wr_data0 = 32'h0000_1234;
    rd_addr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL basic_r0_bypass: got %h expected 0", rd_data[31:0]);
    end
    @(negedge clk);
    wr_en0 = 1'b0;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0 || rd_data_nb[31:0] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL basic_r0_write: got %h/%h expected 0", rd_data[31:0], rd_data_nb[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h1111_1111;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h2222_2222;
    rd_addr = {5'd7, 5'd7};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h2222_2222) begin
      n_fail++; $display("[TB] FAIL collide_bypass: got %h expected 22222222", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data_nb[63:32] !== 32'h0) begin
      n_fail++; $display("[TB] FAIL collide_nb_old: got %h expected 0", rd_data_nb[63:32]);
    end
    @(negedge clk);
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h2222_2222 || rd_data_nb[31:0] !== 32'h2222_2222) begin
      n_fail++; $display("[TB] FAIL collide_r7: got %h/%h expected 22222222", rd_data[31:0], rd_data_nb[31:0]);
    end
    @(negedge clk);
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h0000_000A;
    wr_en1 = 1'b1; wr_addr1 = 5'd4; wr_data1 = 32'h0000_000B;
    @(negedge clk);
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    rd_addr = {5'd4, 5'd3};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'hA || rd_data[63:32] !== 32'hB) begin
      n_fail++; $display("[TB] FAIL dual_write: got r3=%h r4=%h expected a/b", rd_data[31:0], rd_data[63:32]);
    end
    @(negedge clk);
  endtask

  task automatic test_bypass();
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h0000_5555;
    @(negedge clk);
    wr_en1 = 1'b0;
    wr_en0 = 1'b1; wr_addr0 = 5'd9; wr_data0 = 32'h0000_CAFE;
    rd_addr = {5'd9, 5'd9};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'h0000_CAFE) begin
      n_fail++; $display("[TB] FAIL bypass_same_cycle: got %h expected 0000cafe", rd_data[31:0]);
    end
    n_checks++;
    if (rd_data_nb[31:0] !== 32'h0000_5555 || rd_data_nb[63:32] !== 32'h0000_5555) begin
      n_fail++; $display("[TB] FAIL nobypass_old: got %h expected 00005555", rd_data_nb);
    end
    @(negedge clk);
    wr_en0 = 1'b0;
    #1;
    n_checks++;
    if (rd_data_nb[31:0] !== 32'h0000_CAFE || rd_data[63:32] !== 32'h0000_CAFE) begin
      n_fail++; $display("[TB] FAIL bypass_next_cycle: got %h/%h expected 0000cafe", rd_data_nb[31:0], rd_data[63:32]);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_req();
    int nbusy, ndone, dcyc, nzero, bad;
    for (int a = 1; a < DEPTH; a++) begin
      wr_en0 = 1'b1; wr_addr0 = AW'(a); wr_data0 = DW'(a);
      @(negedge clk);
    end
    wr_en0 = 1'b0;
    rd_addr = {5'd31, 5'd17};
    #1;
    n_checks++;
    if (rd_data[31:0] !== 32'd17 || rd_data[63:32] !== 32'd31) begin
      n_fail++; $display("[TB] FAIL preload: got %h expected r17=11 r31=1f", rd_data);
    end
    clr_req = 1'b1;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL clr_req_busy_delay: got %b expected 0", clr_busy);
    end
    @(negedge clk);
    clr_req = 1'b0;
    count_clear(nbusy, ndone, dcyc, nzero);
    n_checks++;
    if (nbusy != DEPTH) begin
      n_fail++; $display("[TB] FAIL clr_busy_cycles: got %0d expected %0d", nbusy, DEPTH);
    end
    n_checks++;
    if (ndone != 1 || dcyc != DEPTH) begin
      n_fail++; $display("[TB] FAIL clr_done_pulse: got %0d pulses at cycle %0d expected 1 at %0d", ndone, dcyc, DEPTH);
    end
    n_checks++;
    if (nzero != 0) begin
      n_fail++; $display("[TB] FAIL clr_rd_busy: got %0d nonzero reads expected 0", nzero);
    end
    sweep_zero(bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL clr_sweep: got %0d nonzero entries expected 0", bad);
    end
    wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'h0000_0077;
    @(negedge clk);
    wr_en1 = 1'b0;
    rd_addr = {5'd2, 5'd2};
    #1;
    n_checks++;
    if (rd_data !== {32'h77, 32'h77} || rd_data_nb !== {32'h77, 32'h77}) begin
      n_fail++; $display("[TB] FAIL clr_post_write: got %h/%h expected 77 on both ports", rd_data, rd_data_nb);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    int nbusy, ndone, dcyc, nzero, bad;
    wr_en0 = 1'b1; wr_addr0 = 5'd12; wr_data0 = 32'h0000_ABCD;
    @(negedge clk);
    wr_en0 = 1'b0;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    rd_addr = {5'd12, 5'd12};
    reset = 1'b0;
    #1;
    n_checks++;
    if (clr_busy !== 1'b1 || clr_done !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("[TB] FAIL midclr_reset: got busy=%b done=%b rd=%h expected 1/0/0", clr_busy, clr_done, rd_data);
    end
    @(negedge clk);
    reset = 1'b1;
    count_clear(nbusy, ndone, dcyc, nzero);
    n_checks++;
    if (nbusy != DEPTH) begin
      n_fail++; $display("[TB] FAIL midclr_busy_cycles: got %0d expected %0d", nbusy, DEPTH);
    end
    n_checks++;
    if (ndone != 1 || dcyc != DEPTH) begin
      n_fail++; $display("[TB] FAIL midclr_done_pulse: got %0d pulses at cycle %0d expected 1 at %0d", ndone, dcyc, DEPTH);
    end
    sweep_zero(bad);
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("[TB] FAIL midclr_sweep: got %0d nonzero entries expected 0", bad);
    end
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_clear_req();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the pipeline core. It is the next-generation replacement for the single-write, two-read register file. Adds configurable width, depth and read-port count, a second write port with fixed priority, optional write-to-read bypass, and a sequential clear engine. The clear engine zeroes storage after reset or on request, so the storage array can map to RAM-style resources with no per-entry reset. Sits between decode (read addresses) and writeback (two retire lanes).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as zero and writes to it are dropped
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset = 0 resets the block)
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational; port i = bits [i*DATA_W +: DATA_W]
wr_en0  in  1  write enable, lane 0
wr_addr0  in  ADDR_W  write address, lane 0
wr_data0  in  DATA_W  write data, lane 0
wr_en1  in  1  write enable, lane 1 (higher priority)
wr_addr1  in  ADDR_W  write address, lane 1
wr_data1  in  DATA_W  write data, lane 1
clr_req  in  1  request a full clear; sampled only in IDLE
clr_busy  out  1  clear in progress; writes ignored, reads return 0
clr_done  out  1  one-cycle pulse on the last clear cycle

Behaviour:
- FSM states: CLEAR and IDLE.
- Reset (reset = 0, asynchronous):
  - state = CLEAR, clr_ptr = 0, clr_busy = 1, clr_done = 0.
  - Storage is NOT reset.
  - rd_data = 0 while in CLEAR.
- CLEAR:
  - Each clk edge writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr = DEPTH-1: write 0, assert clr_done for that cycle, go to IDLE next edge, set clr_busy = 0.
  - Total duration is exactly DEPTH cycles after reset deasserts; clr_ptr wraps to 0.
  - wr_en0/wr_en1 are ignored and clr_req is ignored.
- IDLE:
  - clr_req = 1 at a clk edge moves to CLEAR with clr_ptr = 0; clr_busy rises the next cycle.
  - Writes presented in that same cycle are still performed.
- Writes (IDLE only):
  - Synchronous on the rising clk edge.
  - A write whose address is 0 is dropped when ZERO_REG = 1.
  - Both lanes to the same address: lane 1 data is stored, lane 0 is discarded.
  - Different addresses: both are stored.
- Reads (combinational, per port i):
  - When clr_busy = 1: 0.
  - Else, when ZERO_REG = 1 and the address is 0: 0.
  - Else, when BYPASS = 1 and wr_en1 is set with wr_addr1 matching: wr_data1.
  - Else, when BYPASS = 1 and wr_en0 is set with wr_addr0 matching: wr_data0.
  - Else: the stored entry.
  - When BYPASS = 0, a read in the cycle of a write returns the old value; the new value is visible from the next cycle.
- Reset asserted mid-clear or mid-operation:
  - Restarts the CLEAR sequence from entry 0.
  - Contents written before the reset are undefined until the clear completes, and are then 0.
- Latency: write-to-read is 0 cycles with bypass, 1 cycle without. Clear takes DEPTH cycles.
- No X may propagate to rd_data for any address after the first clr_done.

Test Plan:
- Reset release with DEPTH = 32:
  - clr_busy = 1 for exactly 32 cycles.
  - clr_done pulses once on cycle 32.
  - After that, every address reads 0 on all NUM_RD ports.
- Basic write/read:
  - Write 0xDEADBEEF to r5 via lane 0; next cycle rd_addr0 = 5 -> rd_data0 = 0xDEADBEEF.
  - rd_addr1 = 0 -> rd_data1 = 0.
  - Write 0x1234 to r0 -> r0 still reads 0.
- Dual-write collision:
  - Same cycle: lane 0 writes r7 = 0x11111111, lane 1 writes r7 = 0x22222222.
  - r7 reads 0x22222222.
  - Separately, lane 0 writes r3 = 0xA and lane 1 writes r4 = 0xB in one cycle -> both stored.
- Bypass:
  - BYPASS = 1: writing r9 = 0xCAFE while rd_addr0 = 9 -> rd_data0 = 0xCAFE in the same cycle.
  - BYPASS = 0: the same stimulus returns the old r9 value, then 0xCAFE one cycle later.
- clr_req in IDLE:
  - Preload r1..r31 with their index, pulse clr_req.
  - Writes during busy are ignored, and all reads are 0 while busy.
  - After clr_done, all entries read 0 and a new write to r2 succeeds.
- Reset mid-clear:
  - Assert reset at clear cycle 10, release it.
  - A full 32-cycle clear reruns from entry 0, with exactly one clr_done.
